sram_mem_responder: RTL and testbench

- Memory-side responder for the ARM pipeline's MEM stage.
- Accepts one 32-bit word read or write request from the core.
- Serves it as two 16-bit accesses to an external asynchronous SRAM, each access lasting a fixed number of wait cycles.
- Drives `ready` low while busy so the core freezes its pipeline until the word completes.

---
 rtl/sram_mem_responder_if.sv | 32 +++
 rtl/sram_mem_responder.sv | 124 ++++++++++++
 tb/tb_sram_mem_responder.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_responder_if.sv
// Core <-> responder <-> SRAM bus bundle.
// master: core/SRAM side; slave: the responder.
interface sram_mem_responder_if #(
  parameter int DATA_LEN      = 32,
  parameter int ADDRESS_LEN   = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16
);
  logic                     rd_en;
  logic                     wr_en;
  logic [ADDRESS_LEN-1:0]   address;
  logic [DATA_LEN-1:0]      write_data;
  logic [DATA_LEN-1:0]      read_data;
  logic                     ready;
  logic [SRAM_ADDR_LEN-1:0] sram_addr;
  logic [SRAM_DATA_LEN-1:0] sram_dq_out;
  logic                     sram_dq_oe;
  logic [SRAM_DATA_LEN-1:0] sram_dq_in;
  logic                     sram_we_n;

  modport master (
    output rd_en, wr_en, address, write_data, sram_dq_in,
    input  read_data, ready, sram_addr, sram_dq_out,
    input  sram_dq_oe, sram_we_n
  );

  modport slave (
    input  rd_en, wr_en, address, write_data, sram_dq_in,
    output read_data, ready, sram_addr, sram_dq_out,
    output sram_dq_oe, sram_we_n
  );
endinterface

// File: rtl/sram_mem_responder.sv
// MEM-stage responder: one 32-bit word as two 16-bit SRAM accesses.
// Ports: clk, rst (async high), bus (slave: core request/ready + SRAM pins).
module sram_mem_responder #(
  parameter int DATA_LEN      = 32,
  parameter int ADDRESS_LEN   = 32,
  parameter int SRAM_ADDR_LEN = 18,
  parameter int SRAM_DATA_LEN = 16,
  parameter int BASE_ADDR     = 1024,
  parameter int WAIT_CYCLES   = 2
) (
  input logic                 clk,
  input logic                 rst,
  sram_mem_responder_if.slave bus
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
  localparam int SD = SRAM_DATA_LEN;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [CW-1:0]            cnt;
  logic                     op_wr;
  logic [ADDRESS_LEN-1:0]   addr_l;
  logic [DATA_LEN-1:0]      data_l;
  logic [DATA_LEN-1:0]      rdata;
  logic [SRAM_ADDR_LEN-1:0] addr_hold;

  logic                     req;
  logic                     last;
  logic [ADDRESS_LEN-1:0]   off;
  logic [SRAM_ADDR_LEN-1:0] addr_cur;

  logic                     rdy;
  logic                     we_n;
  logic                     oe;
  logic [SD-1:0]            dq_out;
  logic [SRAM_ADDR_LEN-1:0] s_addr;

  assign req  = bus.rd_en | bus.wr_en;
  assign last = (cnt == LAST);
  assign off  = (addr_l - ADDRESS_LEN'(BASE_ADDR)) >> 2;
  // halfword index: word offset with the half select as LSB
  assign addr_cur = SRAM_ADDR_LEN'({off, state == HIGH});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (req)  state_nxt = LOW;
      LOW:     if (last) state_nxt = HIGH;
      HIGH:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy    = 1'b0;
    we_n   = 1'b1;
    oe     = 1'b0;
    dq_out = '0;
    s_addr = addr_hold;
    unique case (state)
      IDLE: rdy = ~req;
      LOW, HIGH: begin
        s_addr = addr_cur;
        if (op_wr) begin
          we_n   = 1'b0;
          oe     = 1'b1;
          dq_out = (state == HIGH) ? data_l[DATA_LEN-1:SD]
                                   : data_l[SD-1:0];
        end
      end
      DONE: rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      op_wr     <= 1'b0;
      addr_l    <= '0;
      data_l    <= '0;
      rdata     <= '0;
      addr_hold <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req) begin
            op_wr  <= bus.wr_en;
            addr_l <= bus.address;
            data_l <= bus.write_data;
            cnt    <= '0;
          end
        end
        LOW, HIGH: begin
          addr_hold <= addr_cur;
          cnt <= last ? '0 : cnt + CW'(1);
          if (last && !op_wr) begin
            if (state == LOW) rdata[SD-1:0] <= bus.sram_dq_in;
            else rdata[DATA_LEN-1:SD] <= bus.sram_dq_in;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready       = rdy;
  assign bus.read_data   = rdata;
  assign bus.sram_addr   = s_addr;
  assign bus.sram_dq_out = dq_out;
  assign bus.sram_dq_oe  = oe;
  assign bus.sram_we_n   = we_n;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: WAIT_CYCLES=2 and =1 builds
// against a word-level reference memory and halfword SRAM models.
module tb_sram_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_mem_responder_if b0 ();
  sram_mem_responder_if b1 ();

  sram_mem_responder #(.WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  sram_mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  bit [15:0] sram0 [256];
  bit [15:0] sram1 [256];
  int we0 = 0;

  assign b0.sram_dq_in = sram0[b0.sram_addr[7:0]];
  assign b1.sram_dq_in = sram1[b1.sram_addr[7:0]];

  always @(posedge clk) begin
    if (!b0.sram_we_n) sram0[b0.sram_addr[7:0]] <= b0.sram_dq_out;
    if (!b1.sram_we_n) sram1[b1.sram_addr[7:0]] <= b1.sram_dq_out;
    if (!b0.sram_we_n) we0 <= we0 + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input int s, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (s == 0) begin
      b0.rd_en = rd; b0.wr_en = wr;
      b0.address = a; b0.write_data = d;
    end else begin
      b1.rd_en = rd; b1.wr_en = wr;
      b1.address = a; b1.write_data = d;
    end
  endtask

  function automatic bit rdy(input int s);
    return (s == 0) ? b0.ready : b1.ready;
  endfunction

  // counts ready-low cycles; request dropped and inputs scrambled
  task automatic run(input int s, output int lowc);
    lowc = 0;
    while (!rdy(s) && lowc < 40) begin
      lowc++;
      @(negedge clk);
      drive(s, 1'b0, 1'b0, $urandom, $urandom);
      #1;
    end
  endtask

  task automatic access(input int s, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lowc);
    @(negedge clk);
    drive(s, rd, wr, a, d);
    #1;
    run(s, lowc);
  endtask

  bit [31:0] refm [32];
  bit [31:0] exp_rd;
  bit [31:0] d;
  int lc, w0, idx;
  logic [31:0] a;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    chk("rst_ready", b0.ready, 1);
    chk("rst_we_n", b0.sram_we_n, 1);
    chk("rst_oe", b0.sram_dq_oe, 0);
    chk("rst_rdata", b0.read_data, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 0;

    w0 = we0;
    access(0, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lc);
    refm[0] = 32'hDEADBEEF;
    chk("wr_lat", lc, 5);
    chk("wr_we_cycles", we0 - w0, 4);
    chk("wr_half0", sram0[0], 16'hBEEF);
    chk("wr_half1", sram0[1], 16'hDEAD);
    chk("wr_rd_hold", b0.read_data, exp_rd);

    access(0, 1'b1, 1'b0, 32'd1024, 32'd0, lc);
    exp_rd = refm[0];
    chk("rd_lat", lc, 5);
    chk("rd_data", b0.read_data, exp_rd);

    access(0, 1'b0, 1'b1, 32'd1030, 32'h12345678, lc);
    refm[1] = 32'h12345678;
    chk("map_h2", sram0[2], 16'h5678);
    chk("map_h3", sram0[3], 16'h1234);
    chk("map_h0", sram0[0], 16'hBEEF);
    chk("map_h1", sram0[1], 16'hDEAD);

    d = $urandom;
    access(0, 1'b1, 1'b1, 32'd1032, d, lc);
    refm[2] = d;
    chk("prio_rd_hold", b0.read_data, exp_rd);
    chk("prio_word", {sram0[5], sram0[4]}, d);

    repeat (24) begin
      idx = $urandom_range(0, 31);
      a = 32'd1024 + 32'(idx * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        access(0, 1'b0, 1'b1, a, d, lc);
        refm[idx] = d;
        chk("rnd_wr_rd_hold", b0.read_data, exp_rd);
      end else begin
        access(0, 1'b1, 1'b0, a, 32'd0, lc);
        exp_rd = refm[idx];
        chk("rnd_rd", b0.read_data, exp_rd);
      end
      chk("rnd_lat", lc, 5);
    end

    for (int i = 0; i < 32; i++)
      chk("mem_word", {sram0[2*i+1], sram0[2*i]}, refm[i]);

    @(negedge clk);
    drive(0, 1'b1, 1'b0, 32'd1028, 32'd0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("part_rd", b0.read_data, {exp_rd[31:16], refm[1][15:0]});
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", b0.ready, 1);
    chk("mid_rst_rdata", b0.read_data, 0);
    chk("mid_rst_we_n", b0.sram_we_n, 1);
    @(negedge clk);
    rst = 1'b0;
    access(0, 1'b1, 1'b0, 32'd1028, 32'd0, lc);
    chk("post_rst_lat", lc, 5);
    chk("post_rst_rd", b0.read_data, refm[1]);

    access(1, 1'b0, 1'b1, 32'd1024, 32'hA5A5_0F0F, lc);
    chk("w1_wr_lat", lc, 3);
    access(1, 1'b0, 1'b1, 32'd1028, 32'h1357_2468, lc);
    chk("w1_wr2_lat", lc, 3);
    access(1, 1'b1, 1'b0, 32'd1024, 32'd0, lc);
    chk("w1_rd_lat", lc, 3);
    chk("w1_rd", b1.read_data, 32'hA5A5_0F0F);
    access(1, 1'b1, 1'b0, 32'd1028, 32'd0, lc);
    chk("w1_rd2_lat", lc, 3);
    chk("w1_rd2", b1.read_data, 32'h1357_2468);

    drive(1, 1'b1, 1'b0, 32'd1024, 32'd0);
    #1;
    chk("w1_done_ready", b1.ready, 1);
    @(negedge clk);
    #1;
    chk("w1_idle_low", b1.ready, 0);
    run(1, lc);
    chk("w1_early_lat", lc, 3);
    chk("w1_early_rd", b1.read_data, 32'hA5A5_0F0F);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
